ol101_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one overlapping "101" Mealy sequence detector among N_REQ serial bit-stream requesters. It grants one requester at a time for a burst of up to BURST accepted bits and steers that requester's bits into the detector. It reports each match tagged with the owner id, plus a per-burst match count when the grant is released. The detector is cleared between owners, so patterns never span two requesters.

---
 rtl/ol101_pkg.sv | 37 +++
 rtl/ol101_detector.sv | 39 +++
 rtl/ol101_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_ol101_stream_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ol101_pkg.sv
// Shared encodings and round-robin search for the "101" stream arbiter.
package ol101_pkg;

    typedef logic [1:0] ctl_state_t;
    typedef logic [1:0] det_state_t;

    localparam ctl_state_t StIdle    = 2'd0;
    localparam ctl_state_t StStream  = 2'd1;
    localparam ctl_state_t StRelease = 2'd2;

    localparam det_state_t DetS0 = 2'b00;
    localparam det_state_t DetS1 = 2'b01;
    localparam det_state_t DetS2 = 2'b10;

    localparam int unsigned MaxReq  = 32;
    localparam int unsigned MaxReqW = 5;

    // First set request at or after ptr, wrapping modulo n; 0 when none is set.
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned win;
        int unsigned idx;
        logic found;
        win = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            idx = (ptr + i) % n;
            if ((i < n) && !found && req[idx[MaxReqW-1:0]]) begin
                win = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/ol101_detector.sv
// Overlapping "101" Mealy detector; hit is combinational on the accepted bit.
module ol101_detector
    import ol101_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bit_in,
    input  logic accept,
    output logic hit
);

    det_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = DetS0;
        end else if (accept) begin
            unique case (state_q)
                DetS0:   state_d = bit_in ? DetS1 : DetS0;
                DetS1:   state_d = bit_in ? DetS1 : DetS2;
                DetS2:   state_d = bit_in ? DetS1 : DetS0;
                default: state_d = DetS0;
            endcase
        end
    end

    assign hit = (state_q == DetS2) && bit_in && accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DetS0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/ol101_stream_arbiter.sv
// Round-robin arbiter granting bursts of serial bits into one shared "101" detector.
module ol101_stream_arbiter
    import ol101_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned BURST = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           bit_in,
    input  logic [N_REQ-1:0]           bit_vld,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       match,
    output logic [$clog2(N_REQ)-1:0]   match_id,
    output logic                       done,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       busy
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned BC_W = (BURST > 1) ? $clog2(BURST) : 1;

    ctl_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             match_q, match_d;
    logic [ID_W-1:0]  match_id_q, match_id_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    logic             owner_req;
    logic             accept;
    logic             hit;
    logic             det_clr;
    logic [CNT_W-1:0] mcnt_inc;
    int unsigned      winner;

    assign owner_req = req[owner_q];
    assign accept    = (state_q == StStream) && owner_req && bit_vld[owner_q];
    assign det_clr   = (state_q == StRelease);
    assign mcnt_inc  = (hit && (mcnt_q != '1)) ? mcnt_q + CNT_W'(1) : mcnt_q;
    assign winner    = rr_pick(MaxReq'(req), 32'(ptr_q), N_REQ);

    ol101_detector u_detector (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (det_clr),
        .bit_in  (bit_in[owner_q]),
        .accept  (accept),
        .hit     (hit)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        bcnt_d      = bcnt_q;
        mcnt_d      = mcnt_q;
        match_d     = hit;
        match_id_d  = hit ? owner_q : match_id_q;
        done_d      = 1'b0;
        match_cnt_d = match_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = N_REQ'(1) << winner;
                    owner_d = ID_W'(winner);
                    bcnt_d  = '0;
                    mcnt_d  = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (!owner_req) begin
                    grant_d     = '0;
                    done_d      = 1'b1;
                    match_cnt_d = mcnt_q;
                    state_d     = StRelease;
                end else if (accept) begin
                    mcnt_d = mcnt_inc;
                    bcnt_d = bcnt_q + BC_W'(1);
                    // Final bit of the burst: its own hit is folded into the reported count.
                    if (bcnt_q == BC_W'(BURST - 1)) begin
                        grant_d     = '0;
                        done_d      = 1'b1;
                        match_cnt_d = mcnt_inc;
                        state_d     = StRelease;
                    end
                end
            end
            StRelease: begin
                ptr_d   = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + ID_W'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            bcnt_q      <= '0;
            mcnt_q      <= '0;
            match_q     <= 1'b0;
            match_id_q  <= '0;
            done_q      <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            bcnt_q      <= bcnt_d;
            mcnt_q      <= mcnt_d;
            match_q     <= match_d;
            match_id_q  <= match_id_d;
            done_q      <= done_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign owner_id  = owner_q;
    assign match     = match_q;
    assign match_id  = match_id_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ol101_stream_arbiter.sv
// Directed bench for ol101_stream_arbiter: vector table plus multi-cycle sequences.
module tb_ol101_stream_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] bit_vld;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       match;
    logic [1:0] match_id;
    logic       done;
    logic [7:0] match_cnt;
    logic       busy;

    int total;
    int bad;

    typedef struct {
        logic [3:0] req;
        logic [3:0] bin;
        logic [3:0] vld;
        logic [3:0] exp_grant;
        logic       exp_match;
        logic       exp_done;
        logic       exp_busy;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    ol101_stream_arbiter #(
        .N_REQ (4),
        .BURST (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .grant     (grant),
        .owner_id  (owner_id),
        .match     (match),
        .match_id  (match_id),
        .done      (done),
        .match_cnt (match_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] v);
        req = r;
        bit_in = b;
        bit_vld = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int exp_own[4];
        int n;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000);

        // Single requester 0 streaming 1,0,1,0,1,1,0,1.
        vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[7] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 8'd3};
        vecs[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd3};

        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_match_id", 32'(match_id), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].req, vecs[i].bin, vecs[i].vld);
            step();
            check($sformatf("t1_v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("t1_v%0d_match", i), 32'(match), 32'(vecs[i].exp_match));
            check($sformatf("t1_v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("t1_v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("t1_v%0d_cnt", i), 32'(match_cnt), 32'(vecs[i].exp_cnt));
        end

        // Round robin between requesters 1 and 3.
        do_reset();
        exp_own = '{1, 3, 1, 3};
        drive(4'b1010, 4'b0000, 4'b1111);
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (grant == 4'b0000 && n < 30) begin
                step();
                n++;
            end
            check($sformatf("rr%0d_grant", g), 32'(grant), 32'(4'b0001 << exp_own[g]));
            check($sformatf("rr%0d_owner", g), 32'(owner_id), 32'(exp_own[g]));
            n = 0;
            while (grant != 4'b0000 && n < 30) begin
                step();
                n++;
            end
            check($sformatf("rr%0d_len", g), 32'(n), 32'd8);
            check($sformatf("rr%0d_done", g), 32'(done), 32'd1);
            check($sformatf("rr%0d_cnt", g), 32'(match_cnt), 32'd0);
        end

        // Owner 2 leaves the detector in S2; owner 3 must start clean.
        do_reset();
        drive(4'b0100, 4'b0000, 4'b0000);
        step();
        check("iso_grant2", 32'(grant), 32'(4'b0100));
        drive(4'b0100, 4'b0100, 4'b0100);
        step();
        drive(4'b0100, 4'b0000, 4'b0100);
        step();
        drive(4'b1000, 4'b1100, 4'b1100);
        step();
        check("iso_drop_done", 32'(done), 32'd1);
        check("iso_drop_cnt", 32'(match_cnt), 32'd0);
        drive(4'b1000, 4'b0000, 4'b0000);
        step();
        step();
        check("iso_grant3", 32'(grant), 32'(4'b1000));
        check("iso_owner3", 32'(owner_id), 32'd3);
        drive(4'b1000, 4'b1000, 4'b1000);
        step();
        check("iso_b1_match", 32'(match), 32'd0);
        drive(4'b1000, 4'b0000, 4'b1000);
        step();
        check("iso_b2_match", 32'(match), 32'd0);
        drive(4'b1000, 4'b1000, 4'b1000);
        step();
        check("iso_b3_match", 32'(match), 32'd1);
        check("iso_b3_id", 32'(match_id), 32'd3);

        // bit_vld gaps on owner 0, then fill to BURST to confirm the counter.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b0000);
        step();
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        check("gap_b1_match", 32'(match), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0001, 4'b0000);
            step();
            check($sformatf("gap_idle%0d_match", k), 32'(match), 32'd0);
        end
        drive(4'b0001, 4'b0000, 4'b0001);
        step();
        check("gap_b2_match", 32'(match), 32'd0);
        drive(4'b0001, 4'b0001, 4'b0000);
        step();
        check("gap_idle_match", 32'(match), 32'd0);
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        check("gap_b3_match", 32'(match), 32'd1);
        check("gap_b3_id", 32'(match_id), 32'd0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 4'b0000, 4'b0001);
            step();
            check($sformatf("gap_fill%0d_done", k), 32'(done), (k == 4) ? 32'd1 : 32'd0);
        end
        check("gap_cnt", 32'(match_cnt), 32'd1);

        // Drop req after four accepted bits; the bit offered in the drop cycle is ignored.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b0000);
        step();
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        drive(4'b0001, 4'b0000, 4'b0001);
        step();
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        check("drop_b3_match", 32'(match), 32'd1);
        drive(4'b0001, 4'b0000, 4'b0001);
        step();
        drive(4'b0000, 4'b0001, 4'b0001);
        step();
        check("drop_done", 32'(done), 32'd1);
        check("drop_match", 32'(match), 32'd0);
        check("drop_grant", 32'(grant), 32'd0);
        check("drop_cnt", 32'(match_cnt), 32'd1);

        // Asynchronous reset mid-burst with the detector in S2.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b0000);
        step();
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        drive(4'b0001, 4'b0000, 4'b0001);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_match", 32'(match), 32'd0);
        step();
        reset_n = 1'b1;
        check("ar_hold_done", 32'(done), 32'd0);
        drive(4'b0001, 4'b0000, 4'b0000);
        step();
        check("ar_regrant", 32'(grant), 32'(4'b0001));
        drive(4'b0001, 4'b0001, 4'b0001);
        step();
        check("ar_b1_match", 32'(match), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
